// File: rtl/demux4_pkg.sv
// Shared definitions for the 1-to-4 demultiplexer: channel count, select and slot
// encodings, counter width and a select decode helper.
package demux4_pkg;

    localparam int unsigned NumCh = 4;
    localparam int unsigned SelW  = 2;
    localparam int unsigned CntW  = 16;

    typedef enum logic [SelW-1:0] {
        SEL_A = 2'b00,
        SEL_B = 2'b01,
        SEL_C = 2'b10,
        SEL_D = 2'b11
    } sel_e;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_e;

    // One-hot channel mask for a destination select
    function automatic logic [NumCh-1:0] sel_onehot(input sel_e sel);
        return NumCh'(1) << sel;
    endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry output slot: loads a beat on load_i, empties on pop_i without load.
// Payload is kept after a pop so the output shows the last delivered value.
module demux_slot
    import demux4_pkg::*;
#(
    parameter int unsigned Width = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic             pop_i,
    input  logic [Width-1:0] data_i,
    output slot_state_e      state_o,
    output logic [Width-1:0] data_o
);

    slot_state_e      r_state;
    logic [Width-1:0] r_data;

    // Simultaneous load and pop keeps the slot FULL with the new beat
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= EMPTY;
            r_data  <= '0;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (load_i) begin
                        r_state <= FULL;
                        r_data  <= data_i;
                    end
                end
                FULL: begin
                    if (load_i) begin
                        r_data <= data_i;
                    end else if (pop_i) begin
                        r_state <= EMPTY;
                    end
                end
                default: r_state <= EMPTY;
            endcase
        end
    end

    assign state_o = r_state;
    assign data_o  = r_data;

endmodule

// File: rtl/demux4_16.sv
// 1-to-4 valid/ready demultiplexer with one-entry slot per channel.
// Optional per-channel accepted-beat counters when DEMUX4_16_CNT_EN is defined.
module demux4_16
    import demux4_pkg::*;
#(
    parameter int unsigned Width = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [SelW-1:0]            sel_i,
    input  logic [Width-1:0]           data_i,
    input  logic                       valid_i,
    output logic                       ready_o,
`ifdef DEMUX4_16_CNT_EN
    output logic [NumCh-1:0][CntW-1:0] cnt_o,
`endif
    output logic [Width-1:0]           a_o,
    output logic [Width-1:0]           b_o,
    output logic [Width-1:0]           c_o,
    output logic [Width-1:0]           d_o,
    output logic                       a_valid_o,
    output logic                       b_valid_o,
    output logic                       c_valid_o,
    output logic                       d_valid_o,
    input  logic                       a_ready_i,
    input  logic                       b_ready_i,
    input  logic                       c_ready_i,
    input  logic                       d_ready_i
);

    sel_e             w_sel;
    logic [NumCh-1:0] w_sel_oh;
    logic [NumCh-1:0] w_full;
    logic [NumCh-1:0] w_ready_dn;
    logic [NumCh-1:0] w_pop;
    logic [NumCh-1:0] w_load;
    logic             w_accept;
    slot_state_e      w_state [NumCh];
    logic [Width-1:0] w_data  [NumCh];

    assign w_sel      = sel_e'(sel_i);
    assign w_sel_oh   = sel_onehot(w_sel);
    assign w_ready_dn = {d_ready_i, c_ready_i, b_ready_i, a_ready_i};
    assign w_pop      = w_full & w_ready_dn;

    // Only the addressed slot gates ready, so a stalled channel never blocks others
    assign ready_o  = ~w_full[sel_i] | w_pop[sel_i];
    assign w_accept = valid_i & ready_o;
    assign w_load   = {NumCh{w_accept}} & w_sel_oh;

    for (genvar g = 0; g < NumCh; g++) begin : g_slot
        demux_slot #(
            .Width (Width)
        ) u_slot (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .load_i  (w_load[g]),
            .pop_i   (w_pop[g]),
            .data_i  (data_i),
            .state_o (w_state[g]),
            .data_o  (w_data[g])
        );
        assign w_full[g] = (w_state[g] == FULL);
    end

    assign a_o       = w_data[0];
    assign b_o       = w_data[1];
    assign c_o       = w_data[2];
    assign d_o       = w_data[3];
    assign a_valid_o = w_full[0];
    assign b_valid_o = w_full[1];
    assign c_valid_o = w_full[2];
    assign d_valid_o = w_full[3];

`ifdef DEMUX4_16_CNT_EN
    logic [NumCh-1:0][CntW-1:0] r_cnt;

    // Saturating count of beats accepted into each channel
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt <= '0;
        end else begin
            for (int i = 0; i < NumCh; i++) begin
                if (w_load[i] && (r_cnt[i] != {CntW{1'b1}})) begin
                    r_cnt[i] <= r_cnt[i] + CntW'(1);
                end
            end
        end
    end

    assign cnt_o = r_cnt;
`endif

endmodule

// File: tb/tb_demux4_16.sv
// Directed self-checking bench for demux4_16 (counter checks when DEMUX4_16_CNT_EN is defined).
module tb_demux4_16;

    logic        clk_i;
    logic        rst_ni;
    logic [1:0]  sel_i;
    logic [15:0] data_i;
    logic        valid_i;
    logic        ready_o;
    logic [15:0] a_o, b_o, c_o, d_o;
    logic        a_valid_o, b_valid_o, c_valid_o, d_valid_o;
    logic        a_ready_i, b_ready_i, c_ready_i, d_ready_i;
`ifdef DEMUX4_16_CNT_EN
    logic [3:0][15:0] cnt_o;
`endif

    int checks;
    int failures;

    demux4_16 #(.Width(16)) dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .sel_i     (sel_i),
        .data_i    (data_i),
        .valid_i   (valid_i),
        .ready_o   (ready_o),
`ifdef DEMUX4_16_CNT_EN
        .cnt_o     (cnt_o),
`endif
        .a_o       (a_o),
        .b_o       (b_o),
        .c_o       (c_o),
        .d_o       (d_o),
        .a_valid_o (a_valid_o),
        .b_valid_o (b_valid_o),
        .c_valid_o (c_valid_o),
        .d_valid_o (d_valid_o),
        .a_ready_i (a_ready_i),
        .b_ready_i (b_ready_i),
        .c_ready_i (c_ready_i),
        .d_ready_i (d_ready_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Advance one clock and settle just after the rising edge
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Present one beat, clock it in, then drop valid
    task automatic push(input logic [1:0] sel, input logic [15:0] data);
        sel_i   = sel;
        data_i  = data;
        valid_i = 1'b1;
        step();
        valid_i = 1'b0;
    endtask

    task automatic set_ready(input logic [3:0] rdy);
        {d_ready_i, c_ready_i, b_ready_i, a_ready_i} = rdy;
    endtask

    task automatic do_reset();
        rst_ni  = 1'b0;
        valid_i = 1'b0;
        step();
        step();
        @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        checks++;
        if ({a_valid_o, b_valid_o, c_valid_o, d_valid_o} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_init_valid got=%b want=0000", {a_valid_o, b_valid_o, c_valid_o, d_valid_o});
        end
        // Fill all slots, then assert reset asynchronously between edges
        set_ready(4'b0000);
        push(2'd0, 16'h1111);
        push(2'd1, 16'h2222);
        push(2'd2, 16'h3333);
        push(2'd3, 16'h4444);
        checks++;
        if ({a_valid_o, b_valid_o, c_valid_o, d_valid_o} !== 4'b1111) begin
            failures++;
            $display("FAIL reset_prefill got=%b want=1111", {a_valid_o, b_valid_o, c_valid_o, d_valid_o});
        end
        sel_i = 2'd1;
        @(negedge clk_i);
        rst_ni = 1'b0;
        #1;
        checks++;
        if ({a_valid_o, b_valid_o, c_valid_o, d_valid_o} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_async_valid got=%b want=0000", {a_valid_o, b_valid_o, c_valid_o, d_valid_o});
        end
        checks++;
        if ({a_o, b_o, c_o, d_o} !== 64'h0) begin
            failures++;
            $display("FAIL reset_async_data got=%h want=0", {a_o, b_o, c_o, d_o});
        end
        for (int s = 0; s < 4; s++) begin
            sel_i = 2'(s);
            #1;
            checks++;
            if (ready_o !== 1'b1) begin
                failures++;
                $display("FAIL reset_ready sel=%0d got=%b want=1", s, ready_o);
            end
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        checks++;
        if (ready_o !== 1'b1 || a_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_release ready=%b a_valid=%b want=1,0", ready_o, a_valid_o);
        end
    endtask

    task automatic test_routing();
        set_ready(4'b0000);
        sel_i   = 2'b10;
        data_i  = 16'hBEEF;
        valid_i = 1'b1;
        #1;
        checks++;
        if (ready_o !== 1'b1) begin
            failures++;
            $display("FAIL route_ready got=%b want=1", ready_o);
        end
        step();
        valid_i = 1'b0;
        checks++;
        if (c_valid_o !== 1'b1 || c_o !== 16'hBEEF) begin
            failures++;
            $display("FAIL route_c got valid=%b data=%h want 1,beef", c_valid_o, c_o);
        end
        checks++;
        if ({a_valid_o, b_valid_o, d_valid_o} !== 3'b000) begin
            failures++;
            $display("FAIL route_others got=%b want=000", {a_valid_o, b_valid_o, d_valid_o});
        end
        // Pop C; payload must remain visible while EMPTY
        c_ready_i = 1'b1;
        step();
        c_ready_i = 1'b0;
        checks++;
        if (c_valid_o !== 1'b0 || c_o !== 16'hBEEF) begin
            failures++;
            $display("FAIL route_pop got valid=%b data=%h want 0,beef", c_valid_o, c_o);
        end
    endtask

    task automatic test_backpressure();
        set_ready(4'b0000);
        push(2'd1, 16'h0001);
        sel_i   = 2'd1;
        data_i  = 16'h0002;
        valid_i = 1'b1;
        #1;
        checks++;
        if (ready_o !== 1'b0) begin
            failures++;
            $display("FAIL bp_stall_ready got=%b want=0", ready_o);
        end
        step();
        checks++;
        if (b_valid_o !== 1'b1 || b_o !== 16'h0001) begin
            failures++;
            $display("FAIL bp_hold got valid=%b data=%h want 1,0001", b_valid_o, b_o);
        end
        b_ready_i = 1'b1;
        #1;
        checks++;
        if (ready_o !== 1'b1) begin
            failures++;
            $display("FAIL bp_pop_ready got=%b want=1", ready_o);
        end
        step();
        valid_i = 1'b0;
        checks++;
        if (b_valid_o !== 1'b1 || b_o !== 16'h0002) begin
            failures++;
            $display("FAIL bp_second got valid=%b data=%h want 1,0002", b_valid_o, b_o);
        end
        step();
        b_ready_i = 1'b0;
        checks++;
        if (b_valid_o !== 1'b0 || b_o !== 16'h0002) begin
            failures++;
            $display("FAIL bp_drain got valid=%b data=%h want 0,0002", b_valid_o, b_o);
        end
    endtask

    task automatic test_no_hol();
        set_ready(4'b0000);
        push(2'd1, 16'hAAAA);
        sel_i   = 2'd1;
        #1;
        checks++;
        if (ready_o !== 1'b0) begin
            failures++;
            $display("FAIL hol_b_blocked got=%b want=0", ready_o);
        end
        sel_i   = 2'd3;
        data_i  = 16'h1234;
        valid_i = 1'b1;
        #1;
        checks++;
        if (ready_o !== 1'b1) begin
            failures++;
            $display("FAIL hol_d_ready got=%b want=1", ready_o);
        end
        step();
        valid_i = 1'b0;
        checks++;
        if (d_valid_o !== 1'b1 || d_o !== 16'h1234) begin
            failures++;
            $display("FAIL hol_d_data got valid=%b data=%h want 1,1234", d_valid_o, d_o);
        end
        checks++;
        if (b_valid_o !== 1'b1 || b_o !== 16'hAAAA) begin
            failures++;
            $display("FAIL hol_b_kept got valid=%b data=%h want 1,aaaa", b_valid_o, b_o);
        end
        // Both pops in one cycle complete independently
        set_ready(4'b1010);
        step();
        set_ready(4'b0000);
        checks++;
        if ({b_valid_o, d_valid_o} !== 2'b00) begin
            failures++;
            $display("FAIL hol_dual_pop got=%b want=00", {b_valid_o, d_valid_o});
        end
    endtask

    task automatic test_back_to_back();
        set_ready(4'b0001);
        for (int i = 0; i < 8; i++) begin
            sel_i   = 2'd0;
            data_i  = 16'hA000 + 16'(i);
            valid_i = 1'b1;
            #1;
            checks++;
            if (ready_o !== 1'b1) begin
                failures++;
                $display("FAIL b2b_ready beat=%0d got=%b want=1", i, ready_o);
            end
            step();
            checks++;
            if (a_valid_o !== 1'b1 || a_o !== (16'hA000 + 16'(i))) begin
                failures++;
                $display("FAIL b2b_data beat=%0d got valid=%b data=%h want 1,%h", i, a_valid_o, a_o, 16'hA000 + 16'(i));
            end
        end
        valid_i = 1'b0;
        step();
        checks++;
        if (a_valid_o !== 1'b0 || a_o !== 16'hA007) begin
            failures++;
            $display("FAIL b2b_end got valid=%b data=%h want 0,a007", a_valid_o, a_o);
        end
        set_ready(4'b0000);
    endtask

    task automatic test_parallel_pop();
        set_ready(4'b0000);
        push(2'd0, 16'h0A0A);
        push(2'd1, 16'h0B0B);
        push(2'd2, 16'h0C0C);
        push(2'd3, 16'h0D0D);
        checks++;
        if ({a_o, b_o, c_o, d_o} !== 64'h0A0A0B0B0C0C0D0D) begin
            failures++;
            $display("FAIL par_fill got=%h want=0a0a0b0b0c0c0d0d", {a_o, b_o, c_o, d_o});
        end
        set_ready(4'b1111);
        step();
        set_ready(4'b0000);
        checks++;
        if ({a_valid_o, b_valid_o, c_valid_o, d_valid_o} !== 4'b0000) begin
            failures++;
            $display("FAIL par_pop got=%b want=0000", {a_valid_o, b_valid_o, c_valid_o, d_valid_o});
        end
    endtask

`ifdef DEMUX4_16_CNT_EN
    task automatic test_counter();
        do_reset();
        set_ready(4'b1111);
        push(2'd0, 16'h0001);
        push(2'd0, 16'h0002);
        push(2'd0, 16'h0003);
        push(2'd3, 16'h0004);
        checks++;
        if (cnt_o !== {16'd1, 16'd0, 16'd0, 16'd3}) begin
            failures++;
            $display("FAIL cnt_basic got=%h want=0001000000000003", cnt_o);
        end
        sel_i   = 2'd0;
        valid_i = 1'b1;
        for (int i = 0; i < 65536; i++) begin
            data_i = 16'(i);
            step();
        end
        valid_i = 1'b0;
        step();
        checks++;
        if (cnt_o[0] !== 16'hFFFF) begin
            failures++;
            $display("FAIL cnt_sat got=%h want=ffff", cnt_o[0]);
        end
        set_ready(4'b0000);
    endtask
`endif

    initial begin
        checks    = 0;
        failures  = 0;
        sel_i     = 2'd0;
        data_i    = 16'h0;
        valid_i   = 1'b0;
        set_ready(4'b0000);
        do_reset();
        test_reset();
        test_routing();
        test_backpressure();
        test_no_hol();
        test_back_to_back();
        test_parallel_pop();
`ifdef DEMUX4_16_CNT_EN
        test_counter();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/demux4_16.md
DEMUX4_16 -- requirements
Module: demux4_16

Interface
REQ-001 The module SHALL have parameter Width, default 16, meaning the data width of the input and of every output channel.
REQ-002 The module SHALL have one clock; reset is asynchronous and active-low.
REQ-003 clk_i  input  1  clock; all state updates on the rising edge.
REQ-004 rst_ni  input  1  asynchronous active-low reset.
REQ-005 sel_i  input  2  destination select: 00=A, 01=B, 10=C, 11=D; sampled with data_i.
REQ-006 data_i  input  Width  input payload.
REQ-007 valid_i  input  1  input beat valid.
REQ-008 ready_o  output  1  input beat accepted when valid_i && ready_o.
REQ-009 a_o/b_o/c_o/d_o  output  Width each  per-channel registered payload.
REQ-010 a_valid_o/b_valid_o/c_valid_o/d_valid_o  output  1 each  per-channel payload valid.
REQ-011 a_ready_i/b_ready_i/c_ready_i/d_ready_i  input  1 each  per-channel downstream ready.

Function
REQ-012 Each channel SHALL hold a one-entry slot with states EMPTY and FULL; x_valid_o SHALL equal (state==FULL).
REQ-013 Accept SHALL occur when valid_i && ready_o; pop of channel x SHALL occur when x_valid_o && x_ready_i.
REQ-014 ready_o SHALL be combinational: 1 when the slot addressed by sel_i is EMPTY, or FULL and popped in the same cycle; otherwise 0.
REQ-015 On accept, the addressed slot SHALL load data_i at the next edge and be FULL; latency from accept to x_valid_o is exactly 1 cycle.
REQ-016 EMPTY->FULL on accept; FULL->EMPTY on pop without accept to that slot; FULL stays FULL with new data on simultaneous pop and accept (1 beat/cycle per channel sustained).
REQ-017 Non-addressed slots SHALL be unaffected by an accept; a blocked channel SHALL stall only beats addressed to it (ready_o depends on sel_i alone).
REQ-018 x_o SHALL hold its value while FULL and not popped; x_o while EMPTY SHALL retain the last popped value.
REQ-019 Pops on different channels in the same cycle SHALL all complete independently.
REQ-020 No beat SHALL be dropped, duplicated, or reordered within a channel.
REQ-021 valid_i low SHALL cause no state change except pops.

Reset
REQ-022 rst_ni low SHALL immediately force all slots EMPTY, all x_valid_o=0, and all x_o='0.
REQ-023 Reset mid-transfer SHALL discard held beats; ready_o SHALL be 1 during and after reset.
REQ-024 Reset deassertion SHALL be synchronous to clk_i at integration level; the block requires no further init cycles.

Configuration
REQ-025 Macro DEMUX4_16_CNT_EN SHALL, when defined, add output cnt_o [3:0][15:0]: per-channel count of accepted beats, saturating at 16'hFFFF, reset to 0, incremented the cycle after accept.
REQ-026 Without DEMUX4_16_CNT_EN, port cnt_o and the counter logic SHALL be absent; all other behaviour identical.

Structure
REQ-027 Package demux4_pkg SHALL hold NumCh=4, the sel encoding enum (SEL_A..SEL_D), slot state enum (EMPTY, FULL), and counter width 16.
REQ-028 Sub-module demux_slot (one-entry register with load/pop/state) SHALL be instantiated 4 times.

Verification
REQ-029 Reset: rst_ni=0 with slots FULL -> all valid 0, outputs 0, ready_o=1 immediately.
REQ-030 Routing: sel_i=10, data_i=16'hBEEF, valid_i=1 one cycle -> next cycle c_valid_o=1, c_o=16'hBEEF; a/b/d valid stay 0.
REQ-031 Backpressure: b_ready_i=0, two beats 16'h0001,16'h0002 to B -> second beat sees ready_o=0; after b_ready_i=1, B outputs 0001 then 0002 in order.
REQ-032 No HOL blocking: B FULL and b_ready_i=0, beat 16'h1234 to D -> ready_o=1, d_o=16'h1234 next cycle.
REQ-033 Throughput: a_ready_i=1, 8 back-to-back beats to A -> a_valid_o high 8 consecutive cycles, ready_o never 0.
REQ-034 With DEMUX4_16_CNT_EN: 3 beats to A, 1 to D -> cnt_o[0]=3, cnt_o[3]=1, others 0; forced 65536 beats -> cnt_o[0]=16'hFFFF.
